// File: rtl/onchip_memory_pkg.sv
// Shared types and helpers for the on-chip RAM slave.
package onchip_memory_pkg;

    typedef enum logic {
        StClear = 1'b0,
        StReady = 1'b1
    } state_e;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned NUM_BYTES      = DEF_DATA_WIDTH / 8;

    function automatic logic in_range(input logic [31:0] addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/onchip_ram_core.sv
// Byte-enabled synchronous single-port RAM with a registered, read-enabled output.
module onchip_ram_core #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 5120,
    parameter int unsigned AW         = 13
) (
    input  logic                    i_clk,
    input  logic                    i_we,
    input  logic                    i_re,
    input  logic [AW-1:0]           i_addr,
    input  logic [DATA_WIDTH/8-1:0] i_be,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    output logic [DATA_WIDTH-1:0]   o_q
);

    localparam int unsigned NumBe = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_q;

    // No reset here so synthesis can map the array and output register to block RAM.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < int'(NumBe); b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
        if (i_re) begin
            r_q <= r_mem[i_addr];
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/onchip_memory_ctrl.sv
// Avalon-MM on-chip RAM slave: optional post-reset clear, byte writes, 1- or 2-cycle read pipeline.
module onchip_memory_ctrl
    import onchip_memory_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 13,
    parameter int unsigned DEPTH          = 5120,
    parameter int unsigned READ_LATENCY   = 1,
    parameter int unsigned CLEAR_ON_RESET = 1,
    parameter string       INIT_FILE      = ""
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH/8-1:0] byteenable,
    input  logic                    chipselect,
    input  logic                    read,
    input  logic                    write,
    input  logic [DATA_WIDTH-1:0]   writedata,
    output logic                    waitrequest,
    output logic [DATA_WIDTH-1:0]   readdata,
    output logic                    readdatavalid,
    output logic                    clear_done
);

    localparam int unsigned    RamAw      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [RamAw-1:0] ClrLast  = RamAw'(DEPTH - 1);
    localparam state_e         ResetState = (CLEAR_ON_RESET != 0) ? StClear : StReady;

    state_e                  r_state, w_state_next;
    logic [RamAw-1:0]        r_clr_cnt, w_clr_cnt_next;
    logic                    w_accept, w_wr, w_rd, w_in_range;
    logic                    w_ram_we;
    logic [RamAw-1:0]        w_ram_addr;
    logic [DATA_WIDTH/8-1:0] w_ram_be;
    logic [DATA_WIDTH-1:0]   w_ram_wdata, w_ram_q, w_d1;
    logic                    r_v1, r_rng1;

    assign waitrequest = (r_state == StClear);
    assign clear_done  = (r_state == StReady);

    assign w_accept   = chipselect && (read || write) && !waitrequest;
    assign w_wr       = w_accept && write;
    assign w_rd       = w_accept && read && !write;
    assign w_in_range = in_range(32'(address), DEPTH);

    always_comb begin
        w_state_next   = r_state;
        w_clr_cnt_next = r_clr_cnt;
        w_ram_we       = w_wr && w_in_range;
        w_ram_addr     = w_in_range ? RamAw'(address) : '0;
        w_ram_be       = byteenable;
        w_ram_wdata    = writedata;
        unique case (r_state)
            StClear: begin
                w_ram_we    = 1'b1;
                w_ram_addr  = r_clr_cnt;
                w_ram_be    = '1;
                w_ram_wdata = '0;
                if (r_clr_cnt == ClrLast) begin
                    w_state_next   = StReady;
                    w_clr_cnt_next = '0;
                end else begin
                    w_clr_cnt_next = r_clr_cnt + RamAw'(1);
                end
            end
            StReady: begin
            end
            default: w_state_next = ResetState;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ResetState;
            r_clr_cnt <= '0;
            r_v1      <= 1'b0;
            r_rng1    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_clr_cnt <= w_clr_cnt_next;
            r_v1      <= w_rd;
            if (w_rd) begin
                r_rng1 <= w_in_range;
            end
        end
    end

    onchip_ram_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (RamAw)
    ) u_ram (
        .i_clk   (clk),
        .i_we    (w_ram_we),
        .i_re    (w_rd),
        .i_addr  (w_ram_addr),
        .i_be    (w_ram_be),
        .i_wdata (w_ram_wdata),
        .o_q     (w_ram_q)
    );

    // r_rng1 also hides the uninitialised RAM output register until the first read.
    assign w_d1 = r_rng1 ? w_ram_q : '0;

    if (READ_LATENCY >= 2) begin : g_lat2
        logic                  r_v2;
        logic [DATA_WIDTH-1:0] r_d2;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_v2 <= 1'b0;
                r_d2 <= '0;
            end else begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_d2 <= w_d1;
                end
            end
        end

        assign readdatavalid = r_v2;
        assign readdata      = r_d2;
    end else begin : g_lat1
        assign readdatavalid = r_v1;
        assign readdata      = w_d1;
    end

    cov_read_write_together: cover property (@(posedge clk) disable iff (reset)
        chipselect && read && write && !waitrequest);

endmodule

// File: tb/tb_onchip_memory_ctrl.sv
// Randomised self-checking bench: three DUT configurations against a word-array reference model.
module tb_onchip_memory_ctrl;

    localparam int N = 3;
    localparam int unsigned DEP [N] = '{16, 5120, 16};
    localparam int unsigned LAT [N] = '{1, 2, 1};
    localparam int unsigned CLR [N] = '{1, 1, 0};

    logic        clk;
    logic        rst     [N];
    logic [12:0] address [N];
    logic [3:0]  be      [N];
    logic        cs      [N];
    logic        rd      [N];
    logic        wr      [N];
    logic [31:0] wdata   [N];
    logic        wreq    [N];
    logic        rvalid  [N];
    logic        cdone   [N];
    logic [31:0] rdata   [N];

    logic [31:0] mdl   [N][8192];
    bit          known [N][8192];
    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < N; g++) begin : g_dut
        onchip_memory_ctrl #(
            .DATA_WIDTH     (32),
            .ADDR_WIDTH     (13),
            .DEPTH          (DEP[g]),
            .READ_LATENCY   (LAT[g]),
            .CLEAR_ON_RESET (CLR[g]),
            .INIT_FILE      ("")
        ) u_dut (
            .clk           (clk),
            .reset         (rst[g]),
            .address       (address[g]),
            .byteenable    (be[g]),
            .chipselect    (cs[g]),
            .read          (rd[g]),
            .write         (wr[g]),
            .writedata     (wdata[g]),
            .waitrequest   (wreq[g]),
            .readdata      (rdata[g]),
            .readdatavalid (rvalid[g]),
            .clear_done    (cdone[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] expect_word(input int k, input int a);
        if (a >= int'(DEP[k])) return 32'h0;
        return mdl[k][a];
    endfunction

    task automatic model_write(input int k, input int a, input logic [3:0] b, input logic [31:0] d);
        if (a >= int'(DEP[k])) return;
        for (int i = 0; i < 4; i++) if (b[i]) mdl[k][a][i*8 +: 8] = d[i*8 +: 8];
        if (b == 4'hf) known[k][a] = 1'b1;
    endtask

    task automatic model_clear(input int k);
        for (int a = 0; a < int'(DEP[k]); a++) begin
            mdl[k][a]   = 32'h0;
            known[k][a] = 1'b1;
        end
    endtask

    // ---------------- drivers (called just after a falling edge) ----------------
    task automatic idle(input int k);
        cs[k] = 1'b0; rd[k] = 1'b0; wr[k] = 1'b0;
        address[k] = '0; be[k] = '0; wdata[k] = '0;
    endtask

    task automatic cmd(input int k, input bit r, input bit w, input int a,
                       input logic [3:0] b, input logic [31:0] d);
        cs[k] = 1'b1; rd[k] = r; wr[k] = w;
        address[k] = 13'(a); be[k] = b; wdata[k] = d;
        @(posedge clk);
        if (w) model_write(k, a, b, d);
        @(negedge clk);
        idle(k);
    endtask

    task automatic read_word(input int k, input int a, output logic [31:0] data, output int lat);
        cs[k] = 1'b1; rd[k] = 1'b1; address[k] = 13'(a);
        @(posedge clk);
        @(negedge clk);
        idle(k);
        lat = 1;
        while (rvalid[k] !== 1'b1 && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        data = rdata[k];
        if (rvalid[k] !== 1'b1) lat = -1;
    endtask

    task automatic wait_clear(input int k, output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (wreq[k] === 1'b1 && cycles < int'(DEP[k]) + 50);
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            checks++;
            if (wreq[k] !== (CLR[k] != 0)) begin
                errors++; $display("FAIL reset_waitrequest[%0d]: got %b want %b", k, wreq[k], CLR[k] != 0);
            end
            checks++;
            if (cdone[k] !== (CLR[k] == 0)) begin
                errors++; $display("FAIL reset_clear_done[%0d]: got %b want %b", k, cdone[k], CLR[k] == 0);
            end
            checks++;
            if (rvalid[k] !== 1'b0 || rdata[k] !== 32'h0) begin
                errors++; $display("FAIL reset_read_outputs[%0d]: got v=%b d=%h want v=0 d=0", k, rvalid[k], rdata[k]);
            end
        end
    endtask

    task automatic test_clear();
        int c = 0, done0 = 0, done1 = 0, mism = 0, lat;
        logic [31:0] d;
        for (int k = 0; k < N; k++) rst[k] = 1'b0;
        while ((done0 == 0 || done1 == 0) && c < 5300) begin
            @(posedge clk);
            #1;
            c++;
            if (c == 1) begin
                checks++;
                if (wreq[2] !== 1'b0 || cdone[2] !== 1'b1) begin
                    errors++; $display("FAIL no_clear_first_cycle: got wr=%b cd=%b want wr=0 cd=1", wreq[2], cdone[2]);
                end
            end
            if (cdone[0] !== !wreq[0] || cdone[1] !== !wreq[1]) mism++;
            if (done0 == 0 && wreq[0] === 1'b0) done0 = c;
            if (done1 == 0 && wreq[1] === 1'b0) done1 = c;
        end
        checks++;
        if (done0 != int'(DEP[0])) begin
            errors++; $display("FAIL clear_cycles_16: got %0d want %0d", done0, DEP[0]);
        end
        checks++;
        if (done1 != int'(DEP[1])) begin
            errors++; $display("FAIL clear_cycles_5120: got %0d want %0d", done1, DEP[1]);
        end
        checks++;
        if (mism != 0) begin
            errors++; $display("FAIL clear_done_vs_waitrequest: got %0d disagreeing cycles want 0", mism);
        end
        @(negedge clk);
        model_clear(0);
        model_clear(1);
        for (int a = 0; a < int'(DEP[0]); a++) begin
            read_word(0, a, d, lat);
            checks++;
            if (d !== 32'h0 || lat != int'(LAT[0])) begin
                errors++; $display("FAIL cleared_word[%0d]: got %h lat %0d want 00000000 lat %0d", a, d, lat, LAT[0]);
            end
        end
    endtask

    task automatic test_byte_enable();
        int k = 0, lat, a;
        logic [31:0] d;
        cmd(k, 1'b0, 1'b1, 5, 4'b1111, 32'hDEADBEEF);
        cmd(k, 1'b0, 1'b1, 5, 4'b0101, 32'h11223344);
        read_word(k, 5, d, lat);
        checks++;
        if (d !== 32'hDE22BE44 || lat != 1) begin
            errors++; $display("FAIL byte_enable_merge: got %h lat %0d want de22be44 lat 1", d, lat);
        end
        for (int i = 0; i < 40; i++) begin
            a = $urandom_range(15, 0);
            if ($urandom_range(1, 0) == 1) begin
                cmd(k, 1'b0, 1'b1, a, 4'($urandom_range(15, 0)), $urandom);
            end else begin
                read_word(k, a, d, lat);
                checks++;
                if (d !== expect_word(k, a) || lat != int'(LAT[k])) begin
                    errors++; $display("FAIL random_be[%0d]: got %h lat %0d want %h lat %0d", a, d, lat, expect_word(k, a), LAT[k]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int k = 0, lat, a;
        logic [31:0] d, v;
        for (int i = 0; i < 10; i++) begin
            a = $urandom_range(15, 0);
            v = $urandom;
            cmd(k, 1'b0, 1'b1, a, 4'hf, v);
            read_word(k, a, d, lat);
            checks++;
            if (d !== v || lat != 1) begin
                errors++; $display("FAIL write_then_read[%0d]: got %h lat %0d want %h lat 1", a, d, lat, v);
            end
        end
        cmd(k, 1'b0, 1'b1, 7, 4'h0, 32'hCAFEF00D);
        read_word(k, 7, d, lat);
        checks++;
        if (d !== expect_word(k, 7)) begin
            errors++; $display("FAIL zero_byteenable: got %h want %h", d, expect_word(k, 7));
        end
    endtask

    task automatic test_pipelined();
        int k = 1, n;
        int addrs[$];
        for (int a = 0; a < 4; a++) cmd(k, 1'b0, 1'b1, a, 4'hf, 32'(32'h100 + a));
        cmd(k, 1'b0, 1'b1, 5119, 4'hf, $urandom);
        for (int b = 0; b < 2; b++) begin
            addrs.delete();
            if (b == 0) begin
                for (int a = 0; a < 4; a++) addrs.push_back(a);
            end else begin
                for (int i = 0; i < 8; i++) begin
                    if (i % 4 == 3) addrs.push_back(5119);
                    else addrs.push_back(int'($urandom_range(8191, 0)) % (i == 1 ? 4 : 8192));
                end
            end
            n = addrs.size();
            cs[k] = 1'b1; rd[k] = 1'b1; address[k] = 13'(addrs[0]);
            for (int i = 0; i < n + 3; i++) begin
                int j;
                bit ev;
                @(posedge clk);
                @(negedge clk);
                j  = i - (int'(LAT[k]) - 1);
                ev = (j >= 0 && j < n);
                checks++;
                if (rvalid[k] !== ev) begin
                    errors++; $display("FAIL pipe_valid[b%0d s%0d]: got %b want %b", b, i, rvalid[k], ev);
                end
                if (ev) begin
                    checks++;
                    if (rdata[k] !== expect_word(k, addrs[j])) begin
                        errors++; $display("FAIL pipe_data[b%0d s%0d a%0d]: got %h want %h", b, i, addrs[j], rdata[k], expect_word(k, addrs[j]));
                    end
                end
                if (i + 1 < n) address[k] = 13'(addrs[i+1]);
                else idle(k);
            end
        end
    endtask

    task automatic test_out_of_range();
        int k = 1, lat, a;
        logic [31:0] d;
        cmd(k, 1'b0, 1'b1, 5119, 4'hf, 32'h5A5AC3C3);
        cmd(k, 1'b0, 1'b1, 6000, 4'hf, 32'hFFFFFFFF);
        read_word(k, 6000, d, lat);
        checks++;
        if (d !== 32'h0 || lat != 2) begin
            errors++; $display("FAIL oor_read_6000: got %h lat %0d want 00000000 lat 2", d, lat);
        end
        read_word(k, 5119, d, lat);
        checks++;
        if (d !== 32'h5A5AC3C3) begin
            errors++; $display("FAIL last_word_intact: got %h want 5a5ac3c3", d);
        end
        read_word(k, 5120, d, lat);
        checks++;
        if (d !== 32'h0 || lat != 2) begin
            errors++; $display("FAIL oor_read_5120: got %h lat %0d want 00000000 lat 2", d, lat);
        end
        for (int i = 0; i < 20; i++) begin
            a = $urandom_range(8191, 5100);
            if ($urandom_range(1, 0) == 1) begin
                cmd(k, 1'b0, 1'b1, a, 4'hf, $urandom);
            end else begin
                read_word(k, a, d, lat);
                checks++;
                if (d !== expect_word(k, a) || lat != 2) begin
                    errors++; $display("FAIL random_range[%0d]: got %h lat %0d want %h lat 2", a, d, lat, expect_word(k, a));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int k = 1, seen = 0, cyc, lat;
        logic [31:0] d;
        cs[k] = 1'b1; rd[k] = 1'b1; address[k] = 13'd5119;
        @(posedge clk);
        #1;
        rst[k] = 1'b1;
        idle(k);
        repeat (4) begin
            @(negedge clk);
            if (rvalid[k] !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL reset_kills_read: got %0d valid cycles want 0", seen);
        end
        rst[k] = 1'b0;
        wait_clear(k, cyc);
        checks++;
        if (cyc != int'(DEP[k])) begin
            errors++; $display("FAIL clear_after_reset: got %0d want %0d", cyc, DEP[k]);
        end
        rst[k] = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst[k] = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        rst[k] = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst[k] = 1'b0;
        wait_clear(k, cyc);
        checks++;
        if (cyc != int'(DEP[k]) || cdone[k] !== 1'b1) begin
            errors++; $display("FAIL clear_restart: got %0d cd=%b want %0d cd=1", cyc, cdone[k], DEP[k]);
        end
        model_clear(k);
        read_word(k, 5119, d, lat);
        checks++;
        if (d !== expect_word(k, 5119) || lat != 2) begin
            errors++; $display("FAIL recleared_word: got %h lat %0d want %h lat 2", d, lat, expect_word(k, 5119));
        end
    endtask

    task automatic test_priority();
        int k = 2, seen, lat, a;
        bit r, w;
        logic [31:0] d;
        cmd(k, 1'b1, 1'b1, 2, 4'hf, 32'hA5A5A5A5);
        seen = (rvalid[k] !== 1'b0) ? 1 : 0;
        repeat (2) begin
            @(negedge clk);
            if (rvalid[k] !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL rw_no_valid: got %0d valid cycles want 0", seen);
        end
        read_word(k, 2, d, lat);
        checks++;
        if (d !== 32'hA5A5A5A5 || lat != 1) begin
            errors++; $display("FAIL rw_write_wins: got %h lat %0d want a5a5a5a5 lat 1", d, lat);
        end
        for (int i = 0; i < 16; i++) cmd(k, 1'b0, 1'b1, i, 4'hf, $urandom);
        for (int i = 0; i < 30; i++) begin
            a = (i % 7 == 6) ? int'($urandom_range(8191, 16)) : int'($urandom_range(15, 0));
            r = 1'($urandom_range(1, 0));
            w = 1'($urandom_range(1, 0));
            if (w) begin
                cmd(k, r, 1'b1, a, 4'hf, $urandom);
                checks++;
                if (rvalid[k] !== 1'b0) begin
                    errors++; $display("FAIL random_write_valid[%0d]: got %b want 0", a, rvalid[k]);
                end
            end else begin
                read_word(k, a, d, lat);
                checks++;
                if (d !== expect_word(k, a) || lat != 1) begin
                    errors++; $display("FAIL random_noclear[%0d]: got %h lat %0d want %h lat 1", a, d, lat, expect_word(k, a));
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            rst[k] = 1'b1;
            idle(k);
        end
        test_reset();
        test_clear();
        test_byte_enable();
        test_back_to_back();
        test_pipelined();
        test_out_of_range();
        test_reset_mid();
        test_priority();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/onchip_memory_ctrl.md
Name: onchip_memory_ctrl

Overview:
Parametrised single-port on-chip RAM slave for the Qsys fabric. It replaces fixed 32-bit/5120-word instances with configurable width, depth and read latency. It adds a pipelined Avalon-MM read path (readdatavalid), waitrequest back-pressure, and an optional hardware clear sequence after reset so software sees zeroed RAM without an init file. It sits behind the interconnect as an e_avalon_slave for the Nios II instruction and data masters.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
ADDR_WIDTH, 13, word-address width.
DEPTH, 5120, number of implemented words; must be ≤ 2**ADDR_WIDTH.
READ_LATENCY, 1, cycles from accepted read to readdatavalid; legal values are 1 and 2.
CLEAR_ON_RESET, 1, 1 = zero every word after reset before accepting commands.
INIT_FILE, "", hex init image for simulation and synthesis; ignored when CLEAR_ON_RESET=1.

Ports:
clk  in  1  single clock; all logic is rising-edge.
reset  in  1  asynchronous, active-high reset.
address  in  ADDR_WIDTH  word address.
byteenable  in  DATA_WIDTH/8  per-byte write enable.
chipselect  in  1  slave select.
read  in  1  read request.
write  in  1  write request.
writedata  in  DATA_WIDTH  write data.
waitrequest  out  1  high = command not accepted this cycle.
readdata  out  DATA_WIDTH  read data, valid only with readdatavalid.
readdatavalid  out  1  one-cycle pulse per accepted read.
clear_done  out  1  high once the RAM is ready for commands.

Behaviour:
- Reset is asynchronous and active-high and fully asynchronous in assertion. Deassertion is used as-is; the system reset synchroniser upstream handles it.
- Reset values:
  - waitrequest = 1 if CLEAR_ON_RESET, else 0.
  - readdatavalid = 0, readdata = 0.
  - clear_done = !CLEAR_ON_RESET.
  - Clear counter = 0; all pipeline valid bits = 0.
  - RAM contents are not reset by the reset signal itself.
- FSM states:
  - CLEAR: one word is written with zero per cycle at the counter address, all byte lanes enabled. The counter increments each cycle. When the counter reaches DEPTH-1, that word is written and the FSM moves to READY. Clearing takes exactly DEPTH cycles.
  - READY: waitrequest = 0; commands are accepted every cycle.
  - The reset state is CLEAR when CLEAR_ON_RESET=1, otherwise READY.
- A command is accepted when chipselect & (read | write) & !waitrequest.
- Accepted write:
  - Bytes with byteenable=1 are updated at the clock edge; other bytes are unchanged.
  - byteenable = 0 is a legal no-op.
- Accepted read:
  - READ_LATENCY=1: readdatavalid=1 and readdata=mem[address] on the cycle after acceptance (registered RAM output).
  - READ_LATENCY=2: one further output register stage, so the response comes 2 cycles after acceptance.
  - Back-to-back reads are fully pipelined at one per cycle; responses return in order.
- read and write asserted together: write takes priority, no readdatavalid is produced, and the case is flagged by a simulation-only assertion.
- Out-of-range address (address ≥ DEPTH):
  - Write is ignored.
  - Read still produces readdatavalid, with readdata = 0.
- Write then read of the same address on the next cycle returns the new data (ordering is natural to the synchronous write).
- In CLEAR, waitrequest=1; commands are held off by the master and never dropped.
- readdata holds its last value when readdatavalid=0; it is don't-care to masters, but the RTL must not X-propagate.
- Reset asserted mid-read: in-flight readdatavalid pulses are killed and no stale response emerges after reset.
- Reset asserted mid-clear: the clear restarts from address 0.
- clear_done rises in the same cycle waitrequest falls and remains high until the next reset.

Decomposition:
- Package onchip_memory_pkg holds:
  - state typedef (CLEAR, READY);
  - localparam NUM_BYTES = DATA_WIDTH/8;
  - function in_range(addr, depth).
- Sub-module onchip_ram_core: inferred byte-enabled synchronous single-port RAM with write data, byteenable, address and registered q. This keeps it vendor-portable and lets synthesis map it to M9K.
- The controller owns the FSM, clear counter, muxing of clear vs. bus write, the latency pipeline and the range check.

Test Plan:
- Clear sequence: DEPTH=16, CLEAR_ON_RESET=1. Release reset → waitrequest high for exactly 16 cycles, then clear_done=1. Subsequent reads of addresses 0..15 all return 0x00000000.
- Byte-enable write: write 0xDEADBEEF to addr 5 with be=4'b1111, then 0x11223344 with be=4'b0101, then read addr 5 → readdata 0xDE22BE44 one cycle after acceptance (READ_LATENCY=1).
- Pipelined reads, READ_LATENCY=2: preload addr n with value n+0x100 for n=0..3. Issue reads on 4 consecutive cycles → 4 consecutive readdatavalid pulses starting 2 cycles after the first accept, carrying 0x100..0x103 in order.
- Out-of-range access: DEPTH=5120. Write 0xFFFFFFFF to addr 6000, then read addr 6000 → readdatavalid with 0. Reading addr 5119 afterwards returns its prior value, unchanged.
- Reset mid-operation: issue a read at cycle t and assert reset at t+1 (READ_LATENCY=2) → no readdatavalid at t+2. With CLEAR_ON_RESET=1, the clear restarts and takes DEPTH cycles after release.
- Write/read priority and no-clear mode: CLEAR_ON_RESET=0 → waitrequest=0 in the first cycle after reset. Assert read=write=1 with 0xA5A5A5A5 at addr 2 → no readdatavalid; a later read of addr 2 returns 0xA5A5A5A5.
